// File: rtl/bcd_down_counter.sv
// bcd_down_counter
//   Loadable multi-digit BCD countdown timer. The count moves down one step every
//   PRESCALE clock cycles while running. It can be paused and resumed. A
//   one-cycle terminal pulse marks the edge on which the count reaches zero.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   load     in   load the (digit-clamped) preset and return to IDLE; top priority
//   preset   in   BCD preset, digit 0 in [3:0]
//   start    in   begin/resume counting (ignored in IDLE when count is zero)
//   pause    in   suspend counting; outranks start
//   count    out  registered BCD count
//   count_n  out  bitwise complement of count
//   running  out  state is RUN
//   zero     out  count is zero
//   done     out  state is DONE (one cycle, first cycle count reads zero)
module bcd_down_counter #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   count_n,
  output logic                  running,
  output logic                  zero,
  output logic                  done
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [PW-1:0] pre_q,   pre_d;

  logic [W-1:0]      clamp_w;   // preset with each digit saturated at 9
  logic [W-1:0]      dec_w;     // count_q - 1 in BCD
  logic [DIGITS-1:0] borrow;    // borrow into digit g

  assign borrow[0] = 1'b1;

  // Per-digit clamp and decrement; the borrow ripples through every digit
  // combinationally so a multi-digit borrow (e.g. 100 -> 099) lands in one cycle.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] p_dig, c_dig;
    assign p_dig = preset[4*g +: 4];
    assign c_dig = count_q[4*g +: 4];
    assign clamp_w[4*g +: 4] = (p_dig > 4'd9) ? 4'd9 : p_dig;
    assign dec_w[4*g +: 4]   = !borrow[g]      ? c_dig :
                               (c_dig == 4'd0) ? 4'd9  : c_dig - 4'd1;
    if (g < DIGITS - 1) begin : g_brw
      assign borrow[g+1] = borrow[g] & (c_dig == 4'd0);
    end
  end

  logic tick, is_one, is_zero;
  assign tick    = (pre_q == PRE_LAST);
  assign is_one  = (count_q == W'(1));
  assign is_zero = (count_q == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    if (load) begin
      count_d = clamp_w;
      pre_d   = '0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!pause && start && !is_zero) state_d = S_RUN;
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            count_d = dec_w;
            pre_d   = '0;
            // Leaving RUN on the 1 -> 0 step keeps the count from ever wrapping.
            if (is_one) state_d = S_DONE;
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        S_PAUSE: begin
          // Prescaler phase is kept so resume finishes the interrupted step.
          if (!pause && start) state_d = S_RUN;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
    end
  end

  assign count   = count_q;
  assign count_n = ~count_q;
  assign running = (state_q == S_RUN);
  assign zero    = is_zero;
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter
//   Scoreboard bench for bcd_down_counter (DIGITS=2, PRESCALE=4). A decimal
//   reference model predicts the outputs for every driven cycle; the prediction
//   is queued and compared once the DUT has clocked.
module tb_bcd_down_counter;
  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;
  localparam int W        = 4 * DIGITS;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load, start, pause;
  logic [W-1:0] preset;
  logic [W-1:0] count, count_n;
  logic         running, zero, done;

  bcd_down_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .preset(preset), .start(start),
    .pause(pause), .count(count), .count_n(count_n), .running(running),
    .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic         run;
    logic         zr;
    logic         dn;
  } exp_t;

  exp_t  sb_q[$];
  int    errs   = 0;
  int    checks = 0;
  string phase  = "init";

  int m_st, m_val, m_pre;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
    end
  endtask

  function automatic int clamp_val(input logic [W-1:0] p);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      int d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Drive one cycle of inputs, predict, clock, then compare the popped prediction.
  task automatic step(input logic l, input logic [W-1:0] p, input logic s, input logic pa);
    exp_t         e;
    logic [W-1:0] en;
    load = l; preset = p; start = s; pause = pa;
    if (l) begin
      m_val = clamp_val(p); m_pre = 0; m_st = M_IDLE;
    end else begin
      case (m_st)
        M_IDLE:  if (!pa && s && m_val != 0) m_st = M_RUN;
        M_RUN: begin
          if (pa) m_st = M_PAUSE;
          else if (m_pre == PRESCALE - 1) begin
            m_val = m_val - 1; m_pre = 0;
            if (m_val == 0) m_st = M_DONE;
          end else m_pre = m_pre + 1;
        end
        M_PAUSE: if (!pa && s) m_st = M_RUN;
        default: m_st = M_IDLE;
      endcase
    end
    e.cnt = to_bcd(m_val);
    e.run = (m_st == M_RUN);
    e.zr  = (m_val == 0);
    e.dn  = (m_st == M_DONE);
    sb_q.push_back(e);
    @(posedge clk); #1;
    e  = sb_q.pop_front();
    en = ~e.cnt;
    chk("count",   count,   e.cnt);
    chk("count_n", count_n, en);
    chk("running", running, e.run);
    chk("zero",    zero,    e.zr);
    chk("done",    done,    e.dn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Edges from now until the DUT raises done (bounded).
  task automatic run_until_done(output int n);
    n = 0;
    while (n < 300) begin
      step(1'b0, '0, 1'b0, 1'b0);
      n++;
      if (done) break;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_count",   count,   '0);
    chk("rst_count_n", count_n, {W{1'b1}});
    chk("rst_running", running, 1'b0);
    chk("rst_zero",    zero,    1'b1);
    chk("rst_done",    done,    1'b0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; preset = '0;
    m_st = M_IDLE; m_val = 0; m_pre = 0;
    #3;
    phase = "por";
    check_reset_outputs();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a run.
    phase = "t1";
    step(1'b1, 8'h35, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    m_st = M_IDLE; m_val = 0; m_pre = 0;
    #2 rst_n = 1'b1;
    idle(3);

    // Full countdown from 12 with borrow; done exactly 48 edges after RUN entry.
    phase = "t2";
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    run_until_done(n);
    chk("runlen", n, 48);
    idle(2);

    // Per-digit clamp on load.
    phase = "t3";
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'hAF, 1'b0, 1'b0);
    step(1'b1, 8'hF3, 1'b0, 1'b0);

    // Pause mid-step at 07 and resume with the held prescaler phase.
    phase = "t4";
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 100 && m_val != 7; i++) idle(1);
    idle(2);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);   // pause outranks start
    step(1'b0, '0, 1'b1, 1'b0);
    run_until_done(n);
    chk("resume_len", n, 7 * PRESCALE - 2);
    idle(1);

    // Start with zero count is ignored.
    phase = "t5";
    step(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    idle(2);

    // Load during RUN, load+pause together, load in the DONE cycle.
    phase = "t6a";
    step(1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    idle(2);
    phase = "t6b";
    step(1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 8'h20, 1'b0, 1'b1);
    idle(2);
    phase = "t6c";
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && m_st != M_DONE; i++) idle(1);
    chk("reached_done", done, 1'b1);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Synchronous, loadable, multi-digit BCD down counter (countdown timer).
- Complements the existing binary ripple up counters: counts down, the synchronous way, with preset load, pause/resume and a terminal-count pulse.
- Drives seven-segment display decoders and timeout logic.
- Provides true and complemented count outputs, like the existing counter blocks.

Parameters:
- DIGITS, 2, number of BCD digits (count width = 4*DIGITS).
- PRESCALE, 4, clk cycles per decrement while running (>=1; 1 = decrement every cycle).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- load  input  1  load preset into count; state goes to IDLE.
- preset  input  4*DIGITS  BCD preset value, digit 0 in [3:0].
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- count  output  4*DIGITS  current BCD value (registered).
- count_n  output  4*DIGITS  bitwise complement of count.
- running  output  1  high while state is RUN.
- zero  output  1  high when count == 0.
- done  output  1  one-cycle terminal-count pulse.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately regardless of clk):
  - count=0, count_n=all ones, state=IDLE, prescaler=0.
  - running=0, done=0, zero=1.
- States: IDLE, RUN, PAUSE, DONE (2-bit register).
- Input priority in every state: load > pause > start.
- IDLE:
  - load -> count=clamped preset, prescaler=0, stay IDLE.
  - start with count!=0 -> RUN.
  - start with count==0 -> ignored; stay IDLE, no done.
- RUN:
  - prescaler increments every cycle.
  - On a cycle where prescaler==PRESCALE-1: decrement count, prescaler wraps to 0.
  - If that decrement takes count from 1 to 0 -> DONE on the same edge.
  - pause -> PAUSE; count and prescaler hold.
  - load -> IDLE with preset; prescaler=0.
- PAUSE:
  - start -> RUN; prescaler resumes from its held value.
  - load -> IDLE with preset.
  - pause -> ignored (stays PAUSE).
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - load in this cycle -> loads preset, goes IDLE.
- Output decode (all combinational from registers, no extra latency):
  - done = (state==DONE), so it is high in the first cycle count reads 0.
  - running = (state==RUN).
  - zero = (count==0).
- Start latency: start sampled at edge k -> running high after edge k. First decrement occurs at edge k+PRESCALE.
- Total run time: N (decimal value) with no pause -> count reaches 0 exactly N*PRESCALE edges after entering RUN.
- BCD decrement:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit; ripple through all DIGITS in one cycle.
  - Count never wraps below 0, because RUN exits at 0.
- Preset clamp at load: any digit >9 is loaded as 9, per digit.
- count_n is always ~count, including during reset.

Test Plan (DIGITS=2, PRESCALE=4):
1. Pulse rst_n low asynchronously mid-RUN at count=0x35 -> immediately count=0x00, count_n=0xFF, running=0, zero=1, done=0. Remains IDLE after release.
2. load preset=0x12, then start -> count steps 0x12, 0x11, 0x10, 0x09 (borrow), ... one step every 4 cycles. count=0x00 with done=1 for one cycle exactly 48 edges after entering RUN; IDLE next cycle.
3. load preset=0x3C -> count=0x39. load preset=0xAF -> count=0x99.
4. Start from 0x10. Assert pause at count=0x07 for 10 cycles -> count and prescaler frozen, running=0. Then start -> remaining 7*4 cycles minus elapsed prescaler phase, then done.
5. start with count=0x00 in IDLE -> state stays IDLE, running=0, no done pulse.
6. In RUN at count=0x05:
   - load with preset=0x20 -> IDLE, count=0x20, running=0.
   - load and pause in the same cycle -> load wins.
   - load in the DONE cycle -> preset loaded, IDLE.
